// File: rtl/rand_range_sampler_if.sv
// Output stream of rand_range_sampler: head-of-FIFO sample with valid/ready.
// master = sampler side, slave = consumer side.
interface rand_range_sampler_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/rand_range_sampler.sv
// Reduces raw 32-bit LFSR words to uniform samples in [0, limit) by mask-and-reject,
// buffering accepted samples in a DEPTH-entry FIFO. Define SAMPLER_STATS_EN for the reject/drop counters.
module rand_range_sampler #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          rnd_in,
    input  logic                 rnd_valid,
    input  logic [31:0]          limit,
    input  logic                 limit_load,
    rand_range_sampler_if.master out_if,
    output logic [15:0]          reject_cnt,
    output logic [15:0]          drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, CALC, RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] limit_q, limit_d;
    logic [31:0] mask_q, mask_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    logic        empty, full, pop;
    logic [31:0] cand;
    logic        in_range;

    // Smearing limit-1 rightwards yields the smallest 2^k-1 covering it;
    // limit = 0 wraps to all-ones, which is exactly the full-range mask.
    function automatic logic [31:0] smear(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        r = r | (r >> 1);
        r = r | (r >> 2);
        r = r | (r >> 4);
        r = r | (r >> 8);
        r = r | (r >> 16);
        return r;
    endfunction

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign out_if.out_valid = !empty && (state_q != CALC);
    assign out_if.out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign pop      = out_if.out_valid && out_if.out_ready;
    assign cand     = rnd_in & mask_q;
    assign in_range = (limit_q == 32'd0) || (cand < limit_q);

`ifdef SAMPLER_STATS_EN
    logic [15:0] reject_cnt_q, reject_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    assign reject_cnt = reject_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`else
    assign reject_cnt = 16'd0;
    assign drop_cnt   = 16'd0;
`endif

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        mask_d   = mask_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
`ifdef SAMPLER_STATS_EN
        reject_cnt_d = reject_cnt_q;
        drop_cnt_d   = drop_cnt_q;
`endif
        if (limit_load) begin
            // Flushing here already keeps out_valid low for the whole CALC cycle.
            limit_d  = limit;
            state_d  = CALC;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                CALC: begin
                    mask_d   = smear(limit_q - 32'd1);
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    state_d  = RUN;
                end
                RUN: begin
                    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (rnd_valid) begin
                        if (!in_range) begin
`ifdef SAMPLER_STATS_EN
                            if (reject_cnt_q != 16'hFFFF) reject_cnt_d = reject_cnt_q + 16'd1;
`endif
                        end else if (full && !pop) begin
`ifdef SAMPLER_STATS_EN
                            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
                        end else begin
                            mem_d[wr_ptr_q[AW-1:0]] = cand;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            limit_q  <= '0;
            mask_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef SAMPLER_STATS_EN
            reject_cnt_q <= '0;
            drop_cnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            limit_q  <= limit_d;
            mask_q   <= mask_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
`ifdef SAMPLER_STATS_EN
            reject_cnt_q <= reject_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_rand_range_sampler;
    localparam int DEPTH = 4;
`ifdef SAMPLER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rnd_in = '0;
    logic        rnd_valid = 1'b0;
    logic [31:0] limit = '0;
    logic        limit_load = 1'b0;
    logic [15:0] reject_cnt, drop_cnt;
    bit          chk_en = 1'b0;

    int passed = 0;
    int total  = 0;

    rand_range_sampler_if sif ();

    rand_range_sampler #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .limit      (limit),
        .limit_load (limit_load),
        .out_if     (sif.master),
        .reject_cnt (reject_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 mask calculation, 2 sampling.
    int          m_phase = 0;
    logic [31:0] m_limit = '0;
    logic [31:0] m_mask  = '0;
    logic [31:0] q [$];
    int          m_rej  = 0;
    int          m_drop = 0;

    function automatic logic [31:0] model_mask(input logic [31:0] lim);
        longint need;
        if (lim == 32'd0) return 32'hFFFF_FFFF;
        need = longint'(lim) - 1;
        for (int k = 0; k <= 32; k++)
            if (((64'd1 << k) - 1) >= need) return 32'(((64'd1 << k) - 1));
        return 32'hFFFF_FFFF;
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && (m_phase != 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_limit = '0; m_mask = '0; q.delete(); m_rej = 0; m_drop = 0;
        end else begin
            bit pop, was_full;
            logic [31:0] c;
            pop = m_valid() && sif.out_ready;
            if (limit_load) begin
                m_limit = limit; m_phase = 1; q.delete();
            end else if (m_phase == 1) begin
                m_mask = model_mask(m_limit); m_phase = 2; q.delete();
            end else if (m_phase == 2) begin
                was_full = (q.size() == DEPTH);
                if (pop) void'(q.pop_front());
                if (rnd_valid) begin
                    c = rnd_in & m_mask;
                    if (m_limit != 0 && c >= m_limit) begin
                        if (m_rej < 65535) m_rej++;
                    end else if (was_full && !pop) begin
                        if (m_drop < 65535) m_drop++;
                    end else q.push_back(c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out_valid", {31'd0, sif.out_valid}, {31'd0, m_valid()});
            if (m_valid()) check("model_out_data", sif.out_data, q[0]);
            check("model_reject_cnt", {16'd0, reject_cnt}, STATS ? 32'(m_rej) : 32'd0);
            check("model_drop_cnt", {16'd0, drop_cnt}, STATS ? 32'(m_drop) : 32'd0);
        end
    end

    task automatic step(input bit v, input logic [31:0] w, input bit rdy);
        rnd_valid = v; rnd_in = w; sif.out_ready = rdy; limit_load = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [31:0] l);
        limit_load = 1'b1; limit = l; rnd_valid = 1'b0;
        @(posedge clk); #1;
        limit_load = 1'b0;
        check("calc_out_valid", {31'd0, sif.out_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        sif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_out_valid", {31'd0, sif.out_valid}, 32'd0);
        check("rst_out_data", sif.out_data, 32'd0);
        check("rst_reject", {16'd0, reject_cnt}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);

        // limit 10: mask 0xF, 7 accepted, 12 rejected
        load(32'd10);
        step(1, 32'h7, 1);
        check("lim10_valid", {31'd0, sif.out_valid}, 32'd1);
        check("lim10_data", sif.out_data, 32'd7);
        step(1, 32'hC, 1);
        check("lim10_reject_empty", {31'd0, sif.out_valid}, 32'd0);
        check("lim10_reject_cnt", {16'd0, reject_cnt}, STATS ? 32'd1 : 32'd0);

        // full range and single-value range
        load(32'd0);
        step(1, 32'h1234_5678, 0);
        check("lim0_data", sif.out_data, 32'h1234_5678);
        load(32'd1);
        step(1, 32'hDEAD_BEEF, 0);
        check("lim1_data", sif.out_data, 32'd0);

        // overflow: 6 words into 4 entries, then drain in order
        load(32'd0);
        for (int i = 0; i < 6; i++) step(1, 32'hA0 + 32'(i), 0);
        check("ovf_drop_cnt", {16'd0, drop_cnt}, STATS ? 32'd2 : 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", sif.out_data, 32'hA0 + 32'(i));
            step(0, 32'h0, 1);
        end
        check("drain_empty", {31'd0, sif.out_valid}, 32'd0);

        // full FIFO with simultaneous push/pop across pointer wrap
        load(32'd0);
        for (int i = 0; i < 4; i++) step(1, 32'hB0 + 32'(i), 0);
        for (int i = 0; i < 3 * DEPTH; i++) step(1, 32'hC0 + 32'(i), 1);
        check("wrap_drop_cnt", {16'd0, drop_cnt}, STATS ? 32'd2 : 32'd0);
        check("wrap_head", sif.out_data, 32'hC8);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1);

        // reload mid-stream with 3 entries queued
        for (int i = 0; i < 3; i++) step(1, 32'hD0 + 32'(i), 0);
        limit_load = 1'b1; limit = 32'd5; rnd_valid = 1'b1; rnd_in = 32'h1;
        @(posedge clk); #1;
        limit_load = 1'b0; rnd_valid = 1'b0;
        check("reload_valid_calc", {31'd0, sif.out_valid}, 32'd0);
        @(posedge clk); #1;
        step(1, 32'h13, 1);
        check("reload_data", sif.out_data, 32'd3);
        check("reload_keep_rej", {16'd0, reject_cnt}, STATS ? 32'd1 : 32'd0);
        check("reload_keep_drop", {16'd0, drop_cnt}, STATS ? 32'd2 : 32'd0);
        step(1, 32'h6, 1);
        check("lim5_reject_cnt", {16'd0, reject_cnt}, STATS ? 32'd2 : 32'd0);

        // asynchronous reset mid-burst
        step(1, 32'h1, 0);
        step(1, 32'h2, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, sif.out_valid}, 32'd0);
        check("arst_data", sif.out_data, 32'd0);
        check("arst_reject", {16'd0, reject_cnt}, 32'd0);
        check("arst_drop", {16'd0, drop_cnt}, 32'd0);
        #4 reset_n = 1'b1;
        @(posedge clk); #1;
        step(1, 32'h4, 1);
        check("idle_ignores", {31'd0, sif.out_valid}, 32'd0);
        step(0, 32'h0, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rand_range_sampler.md
# rand_range_sampler

Downstream consumer of the 32-bit LFSR word stream. Each cycle it takes one raw pseudorandom word and reduces it to a uniformly distributed value in `[0, limit)` using mask-and-reject sampling. Accepted values go into a small FIFO with a valid/ready output handshake, so bursty consumers do not stall the free-running generator.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  input  1: rising-edge clock.
- `reset_n`  input  1: asynchronous, active-low reset.
- `rnd_in`  input  32: raw LFSR word.
- `rnd_valid`  input  1: `rnd_in` is a fresh word this cycle.
- `limit`  input  32: exclusive upper bound; sampled only when `limit_load` = 1.
- `limit_load`  input  1: single-cycle pulse; captures `limit` and restarts the block.
- `out_data`  output  32: head-of-FIFO sample.
- `out_valid`  output  1: `out_data` is valid.
- `out_ready`  input  1: consumer accepts `out_data` this cycle.
- `reject_cnt`  output  16: saturating count of words rejected by the range test.
- `drop_cnt`  output  16: saturating count of in-range words lost because the FIFO was full.

## Operation
- Reset values: state IDLE, limit register 0, mask 0, FIFO empty, `out_valid` 0, `out_data` 0, both counters 0.
- **IDLE**: ignores `rnd_valid`. On `limit_load`, go to CALC.
- **CALC** (exactly 1 cycle):
  - Flush the FIFO.
  - Compute `mask` as the smallest `2^k − 1` ≥ `limit − 1`.
  - `limit` = 0 means full range: mask = 0xFFFFFFFF and every word is accepted.
  - `limit` = 1 gives mask = 0, so every sample is 0.
  - Then go to RUN.
- **RUN**: on each cycle with `rnd_valid`:
  - Compute `cand = rnd_in & mask`.
  - If `limit` ≠ 0 and `cand ≥ limit`: reject; increment `reject_cnt`.
  - Otherwise, if the FIFO is full and not popping this cycle: drop; increment `drop_cnt`.
  - Otherwise: push `cand`.
- `limit_load` in any state, including RUN mid-stream, goes to CALC.
  - The FIFO is flushed in CALC.
  - `out_valid` is 0 throughout CALC.
  - Counters are *not* cleared by `limit_load`; only reset clears them.
- Pop occurs when `out_valid && out_ready`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (count unchanged).
- Read and write pointers are `log2(DEPTH)+1` bits and wrap naturally. Full/empty are decided from the extra MSB.
- Counters saturate at 0xFFFF and never wrap.
- `out_ready` while `out_valid` = 0 has no effect.

## Timing
- Accepted word on cycle N appears on `out_data` with `out_valid` = 1 at cycle N+1 if the FIFO was empty (1-cycle latency).
- `limit_load` at cycle N:
  - CALC occupies cycle N+1.
  - The first word that can be sampled arrives at cycle N+2.
  - The earliest `out_valid` is cycle N+3.
- `out_data` holds stable while `out_valid && !out_ready`.
- Reset deasserted asynchronously; the first state change is on the first `clk` edge after `reset_n` rises.
- Throughput: one sample per cycle sustained when `out_ready` is held high and all words are accepted.

## Configuration
- `SAMPLER_STATS_EN` defined: `reject_cnt` and `drop_cnt` are implemented as described.
- Not defined: no counter flops; `reject_cnt` and `drop_cnt` are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then `limit_load` with `limit` = 10; `rnd_in` = 0x00000007 valid at cycle 2 → `out_data` = 7, `out_valid` = 1 at cycle 3. Then `rnd_in` = 0x0000000C valid → rejected, `reject_cnt` = 1, nothing pushed (mask = 0xF).
- `limit` = 0 and `rnd_in` = 0x12345678 → `out_data` = 0x12345678. `limit` = 1 and any word → `out_data` = 0.
- `out_ready` = 0, `DEPTH` = 4, 6 accepted words → FIFO holds the first 4, `drop_cnt` = 2. Raise `out_ready` → the 4 words drain in order with no duplicates.
- FIFO full with `out_ready` = 1 and a new accepted word in the same cycle → pop and push both occur, `drop_cnt` unchanged, order preserved across pointer wrap after 3×DEPTH words.
- `limit_load` mid-stream with the FIFO holding 3 entries → `out_valid` = 0 next cycle, old entries never emerge, counters retain their values. Assert `reset_n` low asynchronously mid-burst → all outputs return to reset values immediately.
- Build without `SAMPLER_STATS_EN` and rerun the rejection scenario → identical `out_data` stream, `reject_cnt` = 0.
